// File: rtl/exception_unit_pkg.sv
// Shared definitions for the exception unit: FSM states, cause codes and default vectors.
// Optional ILLEGAL cause is enabled by EXC_ILLEGAL_EN.
package exception_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_HANDLER = 2'd2,
    ST_RETURN  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ITLB    = 2'd1,
    CAUSE_DTLB    = 2'd2,
    CAUSE_ILLEGAL = 2'd3
  } cause_e;

  localparam logic [31:0] DEFAULT_HANDLER_PC = 32'h0000_2000;
  localparam logic [31:0] DEFAULT_BOOT_EPC   = 32'h0000_1000;
  localparam logic [15:0] EXC_COUNT_MAX      = 16'hFFFF;

  // Saturating increment so the counter sticks at all-ones.
  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == EXC_COUNT_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/exception_unit_if.sv
// Pipeline <-> exception unit bus: miss requests in, flush/redirect/status out.
// The illegal_instr request exists only when EXC_ILLEGAL_EN is defined.
interface exception_unit_if;
  logic        stall;
  logic        itlb_miss;
  logic [31:0] itlb_pc;
  logic        dtlb_miss;
  logic [31:0] dtlb_pc;
  logic [31:0] dtlb_vaddr;
  logic        iret;
`ifdef EXC_ILLEGAL_EN
  logic        illegal_instr;
`endif
  logic        privilege;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        flush_ex_mem;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] epc;
  logic [31:0] fault_vaddr;
  logic [1:0]  cause;
  logic [15:0] exc_count;

  modport master (
`ifdef EXC_ILLEGAL_EN
    output illegal_instr,
`endif
    output stall, itlb_miss, itlb_pc, dtlb_miss, dtlb_pc, dtlb_vaddr, iret,
    input  privilege, flush_if_id, flush_id_ex, flush_ex_mem, redirect_valid,
    input  redirect_pc, epc, fault_vaddr, cause, exc_count
  );

  modport slave (
`ifdef EXC_ILLEGAL_EN
    input  illegal_instr,
`endif
    input  stall, itlb_miss, itlb_pc, dtlb_miss, dtlb_pc, dtlb_vaddr, iret,
    output privilege, flush_if_id, flush_id_ex, flush_ex_mem, redirect_valid,
    output redirect_pc, epc, fault_vaddr, cause, exc_count
  );
endinterface

// File: rtl/exception_unit_priority.sv
// exc_priority: picks the oldest pending request (dtlb > illegal > itlb) and its record.
// The illegal request is only present when EXC_ILLEGAL_EN is defined.
module exc_priority
  import exception_unit_pkg::*;
(
`ifdef EXC_ILLEGAL_EN
  input  logic        illegal_instr,
`endif
  input  logic        itlb_miss,
  input  logic [31:0] itlb_pc,
  input  logic        dtlb_miss,
  input  logic [31:0] dtlb_pc,
  input  logic [31:0] dtlb_vaddr,
  output logic        valid,
  output logic [31:0] sel_epc,
  output logic [31:0] sel_vaddr,
  output cause_e      sel_cause
);

  // The memory-stage instruction is older than the one being fetched, so it wins.
  always_comb begin
    valid     = 1'b0;
    sel_epc   = 32'd0;
    sel_vaddr = 32'd0;
    sel_cause = CAUSE_NONE;
    if (dtlb_miss) begin
      valid     = 1'b1;
      sel_epc   = dtlb_pc;
      sel_vaddr = dtlb_vaddr;
      sel_cause = CAUSE_DTLB;
    end
`ifdef EXC_ILLEGAL_EN
    else if (illegal_instr) begin
      valid     = 1'b1;
      sel_epc   = dtlb_pc;
      sel_vaddr = 32'd0;
      sel_cause = CAUSE_ILLEGAL;
    end
`endif
    else if (itlb_miss) begin
      valid     = 1'b1;
      sel_epc   = itlb_pc;
      sel_vaddr = itlb_pc;
      sel_cause = CAUSE_ITLB;
    end
  end

endmodule

// File: rtl/exception_unit.sv
// Exception unit: captures TLB misses (and ILLEGAL with EXC_ILLEGAL_EN), flushes the
// pipeline, redirects to the handler and returns to the saved epc on iret.
module exception_unit
  import exception_unit_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = DEFAULT_HANDLER_PC,
  parameter logic [31:0] BOOT_EPC   = DEFAULT_BOOT_EPC
) (
  input logic             clock,
  input logic             rst,
  exception_unit_if.slave bus
);

  state_e      state_q;
  state_e      state_d;
  logic        capture;
  logic        flush_done;
  logic        return_done;
  logic        req_valid;
  logic [31:0] req_epc;
  logic [31:0] req_vaddr;
  cause_e      req_cause;

  logic        privilege_q;
  logic [31:0] epc_q;
  logic [31:0] fault_vaddr_q;
  cause_e      cause_q;
  logic [15:0] exc_count_q;

  logic        flush_if_id;
  logic        flush_id_ex;
  logic        flush_ex_mem;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  exc_priority u_priority (
`ifdef EXC_ILLEGAL_EN
    .illegal_instr (bus.illegal_instr),
`endif
    .itlb_miss     (bus.itlb_miss),
    .itlb_pc       (bus.itlb_pc),
    .dtlb_miss     (bus.dtlb_miss),
    .dtlb_pc       (bus.dtlb_pc),
    .dtlb_vaddr    (bus.dtlb_vaddr),
    .valid         (req_valid),
    .sel_epc       (req_epc),
    .sel_vaddr     (req_vaddr),
    .sel_cause     (req_cause)
  );

  // Reset lands in HANDLER so the first iret enters user code at BOOT_EPC.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q       <= ST_HANDLER;
      privilege_q   <= 1'b1;
      epc_q         <= BOOT_EPC;
      fault_vaddr_q <= 32'd0;
      cause_q       <= CAUSE_NONE;
      exc_count_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        epc_q         <= req_epc;
        fault_vaddr_q <= req_vaddr;
        cause_q       <= req_cause;
      end
      if (flush_done) begin
        privilege_q <= 1'b1;
        exc_count_q <= sat_inc(exc_count_q);
      end
      if (return_done) begin
        privilege_q <= 1'b0;
        cause_q     <= CAUSE_NONE;
      end
    end
  end

  // Flush/redirect come straight from state and are suppressed while stalled.
  always_comb begin
    state_d        = state_q;
    capture        = 1'b0;
    flush_done     = 1'b0;
    return_done    = 1'b0;
    flush_if_id    = 1'b0;
    flush_id_ex    = 1'b0;
    flush_ex_mem   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    case (state_q)
      ST_RUN: begin
        if (!bus.stall && req_valid) begin
          capture = 1'b1;
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (!bus.stall) begin
          flush_if_id    = 1'b1;
          flush_id_ex    = 1'b1;
          flush_ex_mem   = 1'b1;
          redirect_valid = 1'b1;
          redirect_pc    = HANDLER_PC;
          flush_done     = 1'b1;
          state_d        = ST_HANDLER;
        end
      end
      ST_HANDLER: begin
        if (!bus.stall && bus.iret) begin
          state_d = ST_RETURN;
        end
      end
      ST_RETURN: begin
        if (!bus.stall) begin
          flush_if_id    = 1'b1;
          flush_id_ex    = 1'b1;
          redirect_valid = 1'b1;
          redirect_pc    = epc_q;
          return_done    = 1'b1;
          state_d        = ST_RUN;
        end
      end
      default: state_d = ST_HANDLER;
    endcase
  end

  assign bus.privilege      = privilege_q;
  assign bus.flush_if_id    = flush_if_id;
  assign bus.flush_id_ex    = flush_id_ex;
  assign bus.flush_ex_mem   = flush_ex_mem;
  assign bus.redirect_valid = redirect_valid;
  assign bus.redirect_pc    = redirect_pc;
  assign bus.epc            = epc_q;
  assign bus.fault_vaddr    = fault_vaddr_q;
  assign bus.cause          = cause_q;
  assign bus.exc_count      = exc_count_q;

endmodule
